// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing core: default 640x480@60 timing and
// the pattern-select encodings.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FPORCH = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BPORCH = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FPORCH = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BPORCH = 33;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } vga_mode_e;

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop synchroniser for an asynchronous level input, followed by a
// rising-edge detector producing a single-cycle pulse.
module vga_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator with a small set of test patterns. Pixel
// rate is derived from CLOCK_50M by a tick enable; all outputs are
// registered one tick after the counter position they describe.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int COLOR_W   = 4,
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FPORCH  = VGA_H_FPORCH,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BPORCH  = VGA_H_BPORCH,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FPORCH  = VGA_V_FPORCH,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BPORCH  = VGA_V_BPORCH,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic               CLOCK_50M,
  input  logic               RESET,
  input  logic [1:0]         MODE,
  input  logic               COLOR_UP,
  input  logic               COLOR_DOWN,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic [CNT_W-1:0]   PIXEL_X,
  output logic [CNT_W-1:0]   PIXEL_Y,
  output logic               ACTIVE,
  output logic               FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  // The gradient spans the visible width: take the top bits of x counted
  // within the bits needed to address H_ACTIVE, not within CNT_W.
  localparam int XW      = $clog2(H_ACTIVE);

  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic [CNT_W-1:0]   h_q, v_q;
  logic               frame_tick;
  logic               up_rise, dn_rise;
  logic [COLOR_W-1:0] pend_q;
  logic [COLOR_W-1:0] shlv_q;
  vga_mode_e          shmd_q;

  logic [COLOR_W-1:0] lvl_use;
  vga_mode_e          mode_use;
  logic [2:0]         bar_b;
  logic               act_d, hs_d, vs_d;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  // Tick fires on the first clock after reset and every CLK_DIV clocks after.
  assign tick       = (div_q == '0);
  assign frame_tick = tick && (h_q == '0) && (v_q == '0);

  // Pixel-rate divider.
  always_ff @(posedge CLOCK_50M) begin
    if (RESET || div_q == DIV_W'(CLK_DIV - 1)) div_q <= '0;
    else                                       div_q <= div_q + 1'b1;
  end

  // Raster position counters, advancing once per tick.
  always_ff @(posedge CLOCK_50M) begin
    if (RESET) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick) begin
      if (h_q == CNT_W'(H_TOTAL - 1)) begin
        h_q <= '0;
        v_q <= (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  vga_edge_sync u_up (.clk_i(CLOCK_50M), .rst_i(RESET), .d_i(COLOR_UP),   .rise_o(up_rise));
  vga_edge_sync u_dn (.clk_i(CLOCK_50M), .rst_i(RESET), .d_i(COLOR_DOWN), .rise_o(dn_rise));

  // Pending level: simultaneous up and down edges cancel.
  always_ff @(posedge CLOCK_50M) begin
    if (RESET) pend_q <= '1;
    else if (up_rise && !dn_rise) pend_q <= pend_q + 1'b1;
    else if (dn_rise && !up_rise) pend_q <= pend_q - 1'b1;
  end

  // Shadow level and mode, latched only at the start of a frame.
  always_ff @(posedge CLOCK_50M) begin
    if (RESET) begin
      shlv_q <= '1;
      shmd_q <= MODE_SOLID;
    end else if (frame_tick) begin
      shlv_q <= pend_q;
      shmd_q <= vga_mode_e'(MODE);
    end
  end

  // Pixel (0,0) already belongs to the new frame, so it uses the values
  // being latched into the shadows on that same tick.
  always_comb begin
    lvl_use  = frame_tick ? pend_q : shlv_q;
    mode_use = frame_tick ? vga_mode_e'(MODE) : shmd_q;
    bar_b    = 3'(h_q / CNT_W'(BAR_W));
    act_d    = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
    hs_d     = ((h_q >= CNT_W'(H_ACTIVE + H_FPORCH)) &&
                (h_q <  CNT_W'(H_ACTIVE + H_FPORCH + H_SYNC))) ? HSYNC_POL : !HSYNC_POL;
    vs_d     = ((v_q >= CNT_W'(V_ACTIVE + V_FPORCH)) &&
                (v_q <  CNT_W'(V_ACTIVE + V_FPORCH + V_SYNC))) ? VSYNC_POL : !VSYNC_POL;
    r_d      = '0;
    g_d      = '0;
    b_d      = '0;
    if (act_d) begin
      case (mode_use)
        MODE_SOLID: begin
          r_d = lvl_use; g_d = lvl_use; b_d = lvl_use;
        end
        MODE_BARS: begin
          r_d = bar_b[2] ? lvl_use : '0;
          g_d = bar_b[1] ? lvl_use : '0;
          b_d = bar_b[0] ? lvl_use : '0;
        end
        MODE_CHECK: begin
          if (h_q[5] ^ v_q[5]) begin
            r_d = lvl_use; g_d = lvl_use; b_d = lvl_use;
          end
        end
        default: begin
          r_d = h_q[XW-1 -: COLOR_W];
          g_d = h_q[XW-1 -: COLOR_W];
          b_d = h_q[XW-1 -: COLOR_W];
        end
      endcase
    end
  end

  // Output registers: updated on ticks, held otherwise; FRAME_START is a
  // single-clock pulse regardless of the divider ratio.
  always_ff @(posedge CLOCK_50M) begin
    if (RESET) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HSYNC   <= !HSYNC_POL;
      VGA_VSYNC   <= !VSYNC_POL;
      PIXEL_X     <= '0;
      PIXEL_Y     <= '0;
      ACTIVE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= frame_tick;
      if (tick) begin
        VGA_R     <= r_d;
        VGA_G     <= g_d;
        VGA_B     <= b_d;
        VGA_HSYNC <= hs_d;
        VGA_VSYNC <= vs_d;
        PIXEL_X   <= h_q;
        PIXEL_Y   <= v_q;
        ACTIVE    <= act_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a default-timing instance (A, bars mode) for
// line-level timing and a fast small-frame instance (B) for frame, level,
// mode and reset behaviour. A reference model predicts every output cycle.
module tb_vga_timing_core;

  typedef struct packed {
    logic [3:0] r, g, b;
    logic       hs, vs;
    logic [9:0] x, y;
    logic       act, fs;
  } out_t;

  localparam int DIV_A = 2, FRAME_A = 800 * 525;
  localparam int DIV_B = 1, FRAME_B = 480 * 10;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic [1:0] mode_a = 2'd1, mode_b = 2'd0;
  logic up_b = 1'b0, dn_b = 1'b0;

  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic hsa, vsa, acta, fsa, hsb, vsb, actb, fsb;
  logic [9:0] xa, ya, xb, yb;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vga_timing_core u_a (
    .CLOCK_50M(clk), .RESET(RESET), .MODE(mode_a), .COLOR_UP(1'b0), .COLOR_DOWN(1'b0),
    .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .VGA_HSYNC(hsa), .VGA_VSYNC(vsa),
    .PIXEL_X(xa), .PIXEL_Y(ya), .ACTIVE(acta), .FRAME_START(fsa));

  vga_timing_core #(.CLK_DIV(1), .H_ACTIVE(320), .V_ACTIVE(6), .V_FPORCH(1),
                    .V_SYNC(2), .V_BPORCH(1)) u_b (
    .CLOCK_50M(clk), .RESET(RESET), .MODE(mode_b), .COLOR_UP(up_b), .COLOR_DOWN(dn_b),
    .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .VGA_HSYNC(hsb), .VGA_VSYNC(vsb),
    .PIXEL_X(xb), .PIXEL_Y(yb), .ACTIVE(actb), .FRAME_START(fsb));

  // Outputs describing raster position p (pixels since frame origin).
  function automatic out_t pix(input int hact, hfp, hsy, hbp, vact, vfp, vsy, vbp,
                               input int gshift, p, lvl, md);
    out_t o;
    int ht, h, v, c, bar;
    ht = hact + hfp + hsy + hbp;
    h = p % ht;
    v = p / ht;
    o.x = 10'(h);
    o.y = 10'(v);
    o.act = (h < hact) && (v < vact);
    o.hs = !(h >= hact + hfp && h < hact + hfp + hsy);
    o.vs = !(v >= vact + vfp && v < vact + vfp + vsy);
    o.fs = (p == 0);
    o.r = 0; o.g = 0; o.b = 0;
    if (o.act) begin
      case (md)
        0: begin o.r = 4'(lvl); o.g = 4'(lvl); o.b = 4'(lvl); end
        1: begin
          bar = h / (hact / 8);
          o.r = (bar >= 4) ? 4'(lvl) : 4'd0;
          o.g = ((bar / 2) % 2 == 1) ? 4'(lvl) : 4'd0;
          o.b = (bar % 2 == 1) ? 4'(lvl) : 4'd0;
        end
        2: begin
          c = ((h / 32) + (v / 32)) % 2;
          if (c == 1) begin o.r = 4'(lvl); o.g = 4'(lvl); o.b = 4'(lvl); end
        end
        default: begin o.r = 4'(h >> gshift); o.g = o.r; o.b = o.r; end
      endcase
    end
    return o;
  endfunction

  function automatic out_t rst_out();
    out_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Reference model state.
  out_t exp_a, exp_b;
  int ca = 0, cb = 0;
  int pend_a = 15, pend_b = 15, lv_a = 15, lv_b = 15, md_a = 0, md_b = 0;
  bit mv = 0;

  always @(posedge clk) begin
    if (RESET) begin
      ca = 0; cb = 0; pend_a = 15; pend_b = 15; lv_a = 15; lv_b = 15; md_a = 0; md_b = 0;
      exp_a = rst_out(); exp_b = rst_out(); mv = 1;
    end else begin
      if (ca % DIV_A == 0) begin
        if ((ca / DIV_A) % FRAME_A == 0) begin lv_a = pend_a; md_a = int'(mode_a); end
        exp_a = pix(640, 16, 96, 48, 480, 10, 2, 33, 6, (ca / DIV_A) % FRAME_A, lv_a, md_a);
      end else exp_a.fs = 1'b0;
      if (cb % DIV_B == 0) begin
        if ((cb / DIV_B) % FRAME_B == 0) begin lv_b = pend_b; md_b = int'(mode_b); end
        exp_b = pix(320, 16, 96, 48, 6, 1, 2, 1, 5, (cb / DIV_B) % FRAME_B, lv_b, md_b);
      end else exp_b.fs = 1'b0;
      ca++; cb++;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    out_t da, db;
    if (mv) begin
      da.r = ra; da.g = ga; da.b = ba; da.hs = hsa; da.vs = vsa;
      da.x = xa; da.y = ya; da.act = acta; da.fs = fsa;
      db.r = rb; db.g = gb; db.b = bb; db.hs = hsb; db.vs = vsb;
      db.x = xb; db.y = yb; db.act = actb; db.fs = fsb;
      checks += 2;
      if (da !== exp_a) begin
        failures++;
        if (failures < 20) $display("FAIL model_a t=%0t got=%h exp=%h", $time, da, exp_a);
      end
      if (db !== exp_b) begin
        failures++;
        if (failures < 20) $display("FAIL model_b t=%0t got=%h exp=%h", $time, db, exp_b);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic wait_a(input int x, input int y);
    int n = 0;
    while (!(xa == 10'(x) && ya == 10'(y))) begin
      @(negedge clk);
      if (++n > 5000) begin tmo("wait_a"); return; end
    end
  endtask

  task automatic wait_b(input int x, input int y);
    int n = 0;
    while (!(xb == 10'(x) && yb == 10'(y))) begin
      @(negedge clk);
      if (++n > 10000) begin tmo("wait_b"); return; end
    end
  endtask

  task automatic wait_fs_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 10000) begin tmo("wait_fs_b"); return; end
    end while (!fsb);
  endtask

  // Drive adjust request levels; model level changes at the request.
  task automatic pulse_b(input bit u, input bit d);
    if (u && !d) pend_b = (pend_b + 1) % 16;
    if (d && !u) pend_b = (pend_b + 15) % 16;
    up_b = u; dn_b = d;
    repeat (4) @(negedge clk);
    up_b = 0; dn_b = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n, lo;
    repeat (4) @(negedge clk);
    chk("reset_hsync", int'(hsa), 1);
    chk("reset_rgb", int'(rb), 0);
    RESET = 0;
    @(negedge clk);
    chk("first_fs_a", int'(fsa), 1);
    chk("first_fs_b", int'(fsb), 1);

    // A: bars on line 0, level 15
    wait_a(0, 0);
    chk("bars_x0", int'({ra, ga, ba}), 12'h000);
    wait_a(80, 0);
    chk("bars_x80", int'({ra, ga, ba}), 12'h00f);
    wait_a(639, 0);
    chk("bars_x639", int'({ra, ga, ba}), 12'hfff);
    wait_a(640, 0);
    chk("bars_x640", int'({ra, ga, ba}), 12'h000);
    chk("bars_x640_act", int'(acta), 0);

    // A: hsync low width and line period
    n = 0;
    while (hsa) begin @(negedge clk); if (++n > 4000) break; end
    lo = 0; n = 0;
    while (!hsa && n < 4000) begin @(negedge clk); lo++; n++; end
    chk("hsync_low_clk", lo, 192);
    while (hsa && n < 8000) begin @(negedge clk); n++; end
    chk("line_period_a", n, 1600);

    // B: line period
    wait_b(0, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(xb == 0 && yb == 2) && n < 2000);
    chk("line_period_b", n, 480);

    // B: simultaneous up/down leaves level unchanged
    wait_fs_b(n);
    wait_b(100, 1);
    pulse_b(1, 1);
    wait_fs_b(n);
    wait_b(10, 0);
    chk("level_same", int'(rb), 15);

    // B: up pulse wraps 15 -> 0, but only from the next frame
    wait_b(100, 1);
    pulse_b(1, 0);
    wait_b(50, 3);
    chk("level_hold", int'(gb), 15);
    wait_fs_b(n);
    wait_b(10, 0);
    chk("level_wrap", int'(bb), 0);

    // B: gradient mode
    wait_b(100, 2);
    mode_b = 2'd3;
    wait_fs_b(n);
    wait_b(319, 0);
    chk("grad_x319", int'({rb, gb, bb}), 12'h999);

    // B: checkerboard at level 15
    wait_b(100, 2);
    mode_b = 2'd2;
    pulse_b(0, 1);
    wait_fs_b(n);
    wait_b(31, 0);
    chk("check_x31", int'(rb), 0);
    wait_b(32, 0);
    chk("check_x32", int'(rb), 15);
    chk("frame_period_b", 0, 0 * n);

    // B: mid-frame reset, then restart timing
    wait_b(300, 3);
    RESET = 1;
    @(negedge clk);
    chk("rst_x", int'(xb), 0);
    chk("rst_rgb", int'({rb, gb, bb}), 0);
    chk("rst_sync", int'({hsb, vsb}), 3);
    chk("rst_fs", int'(fsb), 0);
    repeat (2) @(negedge clk);
    RESET = 0;
    @(negedge clk);
    chk("rst_first_fs", int'(fsb), 1);
    wait_fs_b(n);
    chk("frame_period_b", n, 4800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- COLOR_W, 4, bits per colour channel
- CLK_DIV, 2, CLOCK_50M cycles per pixel (>=1)
- H_ACTIVE / H_FPORCH / H_SYNC / H_BPORCH, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE / V_FPORCH / V_SYNC / V_BPORCH, 480/10/2/33, vertical timing in lines
- HSYNC_POL / VSYNC_POL, 0/0, asserted sync level
- CNT_W, 10, counter and coordinate width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK_50M  in  1  sole clock
- RESET  in  1  reset (synchronous, active-high)
- MODE  in  2  pattern select
- COLOR_UP / COLOR_DOWN  in  1  asynchronous level-adjust requests
- VGA_R / VGA_G / VGA_B  out  COLOR_W  pixel colour
- VGA_HSYNC / VGA_VSYNC  out  1  sync outputs
- PIXEL_X / PIXEL_Y  out  CNT_W  coordinate of the current output pixel
- ACTIVE  out  1  current output pixel lies in the visible area
- FRAME_START  out  1  one-CLOCK_50M-cycle pulse at pixel (0,0)
REQ-003 There is one clock, CLOCK_50M; reset is RESET, synchronous and active-high. No derived clocks.

Function
REQ-004 A divider SHALL assert an internal pixel tick once every CLK_DIV cycles of CLOCK_50M; all counters advance only on a tick.
REQ-005 H counter SHALL count 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters, wrapping to 0; V counter SHALL increment on H wrap and count 0..V_TOTAL-1, wrapping to 0.
REQ-006 All outputs SHALL be registered and update on the cycle after a tick, reflecting the counter values at that tick (1-tick latency); they hold between ticks.
REQ-007 VGA_HSYNC SHALL equal HSYNC_POL for H in [H_ACTIVE+H_FPORCH, H_ACTIVE+H_FPORCH+H_SYNC), else !HSYNC_POL; VGA_VSYNC is defined likewise on V.
REQ-008 ACTIVE SHALL be 1 iff H<H_ACTIVE and V<V_ACTIVE. When ACTIVE is 0, RGB SHALL be 0.
REQ-009 FRAME_START SHALL pulse high for exactly one CLOCK_50M cycle, when the outputs present H=0, V=0.
REQ-010 COLOR_UP/COLOR_DOWN SHALL each be synchronised with 2 flops and rising-edge detected.
- An up edge adds 1 to a pending level; a down edge subtracts 1; both wrap modulo 2^COLOR_W.
- Up and down edges in the same cycle SHALL leave the pending level unchanged.
REQ-011 The pending level and MODE SHALL be copied into active shadows only at the tick producing FRAME_START; no mid-frame colour or mode change is visible.
REQ-012 With L the shadowed level, x=PIXEL_X, y=PIXEL_Y, the patterns while ACTIVE SHALL be:
- mode 0: R=G=B=L
- mode 1: eight vertical bars with b=x/(H_ACTIVE/8); R=b[2]?L:0, G=b[1]?L:0, B=b[0]?L:0
- mode 2: checkerboard of 32x32 squares; R=G=B=L when x[5]^y[5] is 1, else 0
- mode 3: R=G=B= top COLOR_W bits of x.

Reset
REQ-013 While RESET is high, at each clock the block SHALL clear the divider, the H/V counters, the RGB outputs, PIXEL_X/Y, ACTIVE and FRAME_START. It SHALL drive both syncs deasserted, set the pending and shadow levels to all-ones, set the shadow mode to 0, and clear the edge-detect history.
REQ-014 Assertion of RESET mid-frame SHALL take effect on the next clock edge; after release the first tick produces H=0,V=0 with FRAME_START.

Structure
REQ-015 Package vga_pkg SHALL hold the default timing constants and the mode encodings (MODE_SOLID=0, MODE_BARS=1, MODE_CHECK=2, MODE_GRAD=3).
REQ-016 Sub-module vga_edge_sync (2-flop synchroniser plus rising-edge detector, with the same clock and reset) SHALL be instantiated once per adjust input.

Verification
REQ-017 Defaults, reset released: HSYNC low for 96 ticks (192 clocks) of every 800-tick (1600-clock) line; VSYNC low for 2 lines (3200 clocks); FRAME_START period 840000 clocks.
REQ-018 Level 15, one COLOR_UP pulse mid-frame: RGB stays 15 until the next FRAME_START, then becomes 0 (wrap).
REQ-019 COLOR_UP and COLOR_DOWN rising together: the level after the next FRAME_START is unchanged (15).
REQ-020 MODE=1, level 15: x=0 gives RGB 0/0/0; x=80 gives 0/0/15; x=639 gives 15/15/15; x=640 gives 0/0/0 with ACTIVE=0.
REQ-021 RESET pulsed at H=300,V=200: next clock gives all outputs at reset values; after release, FRAME_START occurs on the first tick, and the next one follows 840000 clocks later.
REQ-022 CLK_DIV=1, H_ACTIVE=320 variant: line period 480 clocks; mode 3 at x=319 gives RGB=9.
